gcd_rr_scheduler: RTL and testbench

- Shares one subtract-based GCD datapath/controller pair (the "core") between NREQ requesters using round-robin arbitration.
- For each request it latches the operands, starts the core, waits for core done, and returns the result tagged with the requester id over a valid/ready response channel.
- Handles zero operands itself so the core never sees a non-terminating case.

---
 rtl/gcd_rr_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_gcd_rr_scheduler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one subtract-based GCD core among NREQ requesters.
// Optional core-abort watchdog is compiled in with `define GCD_TIMEOUT_EN.
module gcd_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         gnt,
    output logic                    core_start,
    output logic [WIDTH-1:0]        core_a,
    output logic [WIDTH-1:0]        core_b,
    input  logic                    core_done,
    input  logic [WIDTH-1:0]        core_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_r;
    state_e            next_state_s;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   cand_s;
    logic [ID_W-1:0]   win_id_s;
    logic              any_req_s;
    logic [NREQ-1:0]   win_oh_s;
    logic [WIDTH-1:0]  win_a_s;
    logic [WIDTH-1:0]  win_b_s;
    logic              win_zero_s;
    logic              handshake_s;
    logic              timeout_s;

    logic [NREQ-1:0]   gnt_nxt_s;
    logic              core_start_nxt_s;
    logic              rsp_valid_nxt_s;
    logic              busy_nxt_s;

    logic [NREQ-1:0]   gnt_r;
    logic              core_start_r;
    logic [WIDTH-1:0]  core_a_r;
    logic [WIDTH-1:0]  core_b_r;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [WIDTH-1:0]  rsp_result_r;
    logic              rsp_err_r;
    logic              busy_r;

    assign handshake_s = rsp_valid_r & rsp_ready;

    // Round-robin search: first set req bit strictly after the last winner, wrapping
    always_comb begin
        any_req_s = 1'b0;
        win_id_s  = '0;
        cand_s    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = ID_W'((int'(ptr_r) + k) % NREQ);
            if (!any_req_s && req[cand_s]) begin
                any_req_s = 1'b1;
                win_id_s  = cand_s;
            end else begin
                win_id_s  = win_id_s;
            end
        end
        win_oh_s           = '0;
        win_oh_s[win_id_s] = any_req_s;
        win_a_s            = req_a[int'(win_id_s)*WIDTH +: WIDTH];
        win_b_s            = req_b[int'(win_id_s)*WIDTH +: WIDTH];
        win_zero_s         = (win_a_s == '0) || (win_b_s == '0);
    end

`ifdef GCD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_r;

    // WAIT-cycle counter, cleared while the core is being started
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (state_r == ISSUE) begin
            wait_cnt_r <= '0;
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign timeout_s = (state_r == WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; zero operands bypass the core entirely
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s = win_zero_s ? RESP : ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: next_state_s = WAIT;
            WAIT: begin
                if (core_done || timeout_s) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RESP: begin
                if (handshake_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM output decode feeding the output registers (outputs trail the state by one cycle)
    always_comb begin
        gnt_nxt_s        = (state_r == IDLE) ? win_oh_s : '0;
        core_start_nxt_s = (state_r == ISSUE);
        rsp_valid_nxt_s  = (next_state_s == RESP) && (state_r != IDLE);
        busy_nxt_s       = (next_state_s != IDLE);
    end

    // Output registers, job latches and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_r        <= '0;
            core_start_r <= 1'b0;
            core_a_r     <= '0;
            core_b_r     <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= '0;
            rsp_err_r    <= 1'b0;
            busy_r       <= 1'b0;
            ptr_r        <= ID_W'(NREQ - 1);
        end else begin
            gnt_r        <= gnt_nxt_s;
            core_start_r <= core_start_nxt_s;
            rsp_valid_r  <= rsp_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            if (state_r == IDLE && any_req_s) begin
                core_a_r     <= win_a_s;
                core_b_r     <= win_b_s;
                rsp_id_r     <= win_id_s;
                ptr_r        <= win_id_s;
                rsp_result_r <= win_a_s | win_b_s;
                rsp_err_r    <= 1'b0;
            end else if (state_r == WAIT && core_done) begin
                rsp_result_r <= core_result;
                rsp_err_r    <= 1'b0;
            end else if (timeout_s) begin
                rsp_result_r <= '0;
                rsp_err_r    <= 1'b1;
            end
        end
    end

    assign gnt        = gnt_r;
    assign core_start = core_start_r;
    assign core_a     = core_a_r;
    assign core_b     = core_b_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_err    = rsp_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed bench for gcd_rr_scheduler with a behavioural GCD core of programmable latency.
module tb_gcd_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic                  core_start;
    logic [WIDTH-1:0]      core_a;
    logic [WIDTH-1:0]      core_b;
    logic                  core_done = 1'b0;
    logic [WIDTH-1:0]      core_result = '0;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_err;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    int               core_lat   = 3;
    bit               core_never = 1'b0;
    int               start_cnt  = 0;
    logic             core_run   = 1'b0;
    int               core_cnt   = 0;
    logic [WIDTH-1:0] core_res   = '0;

    gcd_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] gcd_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x, y, t;
        x = a;
        y = b;
        for (int i = 0; i < 64 && y != 0; i++) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Core model: done pulses core_lat cycles after it sees core_start
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start) start_cnt <= start_cnt + 1;
        if (!rst_n) begin
            core_run <= 1'b0;
        end else if (core_start) begin
            core_run <= 1'b1;
            core_cnt <= core_lat;
            core_res <= gcd_f(core_a, core_b);
        end else if (core_run && !core_never && core_cnt <= 1) begin
            core_done   <= 1'b1;
            core_result <= core_res;
            core_run    <= 1'b0;
        end else if (core_run) begin
            core_cnt <= core_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == '0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({gnt, core_start, rsp_valid, rsp_err, busy} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000000", {gnt, core_start, rsp_valid, rsp_err, busy});
        end
        checks++;
        if ({core_a, core_b} !== 32'h0) begin
            errors++; $display("FAIL reset_core_ops: got %h expected 0", {core_a, core_b});
        end
        checks++;
        if ({rsp_id, rsp_result} !== 18'h0) begin
            errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_id, rsp_result});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        int n, s0;
        logic [1:0]       exp_id[4];
        logic [WIDTH-1:0] exp_r[4];
        exp_id = '{2'd0, 2'd2, 2'd0, 2'd2};
        exp_r  = '{16'd4, 16'd3, 16'd4, 16'd3};
        s0 = start_cnt;
        core_lat = 3;
        set_op(0, 16'd12, 16'd8);
        set_op(2, 16'd9, 16'd6);
        req = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            wait_gnt(n);
            checks++;
            if (gnt !== (4'b0001 << exp_id[j])) begin
                errors++; $display("FAIL rr_gnt%0d: got %b expected %b", j, gnt, 4'b0001 << exp_id[j]);
            end
            tick();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++; $display("FAIL rr_gnt_pulse%0d: got %b expected 0000", j, gnt);
            end
            wait_valid(n);
            checks++;
            if ({rsp_id, rsp_result, rsp_err} !== {exp_id[j], exp_r[j], 1'b0}) begin
                errors++; $display("FAIL rr_rsp%0d: got id %0d res %0d err %b expected id %0d res %0d err 0",
                                   j, rsp_id, rsp_result, rsp_err, exp_id[j], exp_r[j]);
            end
            if (j == 3) req = 4'b0000;
            tick();
        end
        tick();
        checks++;
        if (start_cnt - s0 !== 4) begin
            errors++; $display("FAIL rr_starts: got %0d expected 4", start_cnt - s0);
        end
    endtask

    task automatic test_basic();
        int n, s0;
        s0 = start_cnt;
        core_lat = 10;
        set_op(1, 16'd48, 16'd18);
        req = 4'b0010;
        tick();
        checks++;
        if ({gnt, core_start} !== 5'b0010_0) begin
            errors++; $display("FAIL basic_gnt: got %b expected 00100", {gnt, core_start});
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, core_start, core_a, core_b} !== {4'b0000, 1'b1, 16'd48, 16'd18}) begin
            errors++; $display("FAIL basic_start: got gnt %b start %b a %0d b %0d expected 0000 1 48 18",
                               gnt, core_start, core_a, core_b);
        end
        wait_valid(n);
        checks++;
        if (n !== 12) begin
            errors++; $display("FAIL basic_latency: got %0d expected 12", n);
        end
        checks++;
        if ({rsp_id, rsp_result, rsp_err} !== {2'd1, 16'd6, 1'b0}) begin
            errors++; $display("FAIL basic_rsp: got id %0d res %0d err %b expected 1 6 0", rsp_id, rsp_result, rsp_err);
        end
        tick();
        checks++;
        if ({rsp_valid, 8'(start_cnt - s0)} !== {1'b0, 8'd1}) begin
            errors++; $display("FAIL basic_done: got valid %b starts %0d expected 0 1", rsp_valid, start_cnt - s0);
        end
    endtask

    task automatic test_zero();
        int s0;
        s0 = start_cnt;
        set_op(3, 16'd0, 16'd35);
        req = 4'b1000;
        tick();
        checks++;
        if ({gnt, core_start, rsp_valid} !== 6'b1000_0_0) begin
            errors++; $display("FAIL zero_gnt: got %b expected 100000", {gnt, core_start, rsp_valid});
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_err} !== {1'b1, 2'd3, 16'd35, 1'b0}) begin
            errors++; $display("FAIL zero_rsp35: got v %b id %0d res %0d err %b expected 1 3 35 0",
                               rsp_valid, rsp_id, rsp_result, rsp_err);
        end
        tick();
        set_op(3, 16'd0, 16'd0);
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++; $display("FAIL zero00_gnt: got %b expected 1000", gnt);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_err} !== {1'b1, 2'd3, 16'd0, 1'b0}) begin
            errors++; $display("FAIL zero_rsp0: got v %b id %0d res %0d err %b expected 1 3 0 0",
                               rsp_valid, rsp_id, rsp_result, rsp_err);
        end
        tick();
        checks++;
        if ({rsp_valid, 8'(start_cnt - s0)} !== 9'h000) begin
            errors++; $display("FAIL zero_nostart: got valid %b starts %0d expected 0 0", rsp_valid, start_cnt - s0);
        end
    endtask

    task automatic test_backpressure();
        int n;
        core_lat = 3;
        set_op(0, 16'd12, 16'd8);
        set_op(1, 16'd48, 16'd18);
        rsp_ready = 1'b0;
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL bp_gnt0: got %b expected 0001", gnt);
        end
        req = 4'b0010;
        wait_valid(n);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, gnt} !== {1'b1, 2'd0, 16'd4, 4'b0000}) begin
                errors++; $display("FAIL bp_hold%0d: got v %b id %0d res %0d gnt %b expected 1 0 4 0000",
                                   c, rsp_valid, rsp_id, rsp_result, gnt);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, gnt, busy} !== 6'b0_0000_0) begin
            errors++; $display("FAIL bp_handshake: got %b expected 000000", {rsp_valid, gnt, busy});
        end
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL bp_next_gnt: got %b expected 0010", gnt);
        end
        req = 4'b0000;
        wait_valid(n);
        checks++;
        if ({rsp_id, rsp_result} !== {2'd1, 16'd6}) begin
            errors++; $display("FAIL bp_rsp1: got id %0d res %0d expected 1 6", rsp_id, rsp_result);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        core_lat = 50;
        set_op(0, 16'd12, 16'd8);
        set_op(2, 16'd9, 16'd6);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({gnt, core_start, rsp_valid, rsp_err, busy} !== 8'h00) begin
            errors++; $display("FAIL mid_reset_ctrl: got %b expected 00000000", {gnt, core_start, rsp_valid, rsp_err, busy});
        end
        checks++;
        if ({core_a, core_b, rsp_id, rsp_result} !== 50'h0) begin
            errors++; $display("FAIL mid_reset_data: got %h expected 0", {core_a, core_b, rsp_id, rsp_result});
        end
        rst_n = 1'b1;
        core_lat = 3;
        req = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL mid_ptr_gnt: got %b expected 0001", gnt);
        end
        req = 4'b0100;
        wait_valid(n);
        checks++;
        if ({rsp_id, rsp_result} !== {2'd0, 16'd4}) begin
            errors++; $display("FAIL mid_rsp0: got id %0d res %0d expected 0 4", rsp_id, rsp_result);
        end
        tick();
        wait_gnt(n);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL mid_gnt2: got %b expected 0100", gnt);
        end
        req = 4'b0000;
        wait_valid(n);
        checks++;
        if ({rsp_id, rsp_result} !== {2'd2, 16'd3}) begin
            errors++; $display("FAIL mid_rsp2: got id %0d res %0d expected 2 3", rsp_id, rsp_result);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        set_op(1, 16'd48, 16'd18);
`ifdef GCD_TIMEOUT_EN
        core_never = 1'b1;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        wait_valid(n);
        checks++;
        if (n !== 16) begin
            errors++; $display("FAIL tmo_latency: got %0d expected 16", n);
        end
        checks++;
        if ({rsp_err, rsp_result, rsp_id} !== {1'b1, 16'd0, 2'd1}) begin
            errors++; $display("FAIL tmo_rsp: got err %b res %0d id %0d expected 1 0 1", rsp_err, rsp_result, rsp_id);
        end
        tick();
        core_never = 1'b0;
        core_lat = 14;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        wait_valid(n);
        checks++;
        if (n !== 16) begin
            errors++; $display("FAIL tmo_edge_latency: got %0d expected 16", n);
        end
        checks++;
        if ({rsp_err, rsp_result} !== {1'b0, 16'd6}) begin
            errors++; $display("FAIL tmo_edge_rsp: got err %b res %0d expected 0 6", rsp_err, rsp_result);
        end
        tick();
`else
        core_lat = 20;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        wait_valid(n);
        checks++;
        if (n !== 22) begin
            errors++; $display("FAIL long_latency: got %0d expected 22", n);
        end
        checks++;
        if ({rsp_err, rsp_result} !== {1'b0, 16'd6}) begin
            errors++; $display("FAIL long_rsp: got err %b res %0d expected 0 6", rsp_err, rsp_result);
        end
        tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_round_robin();
        test_basic();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
